// File: rtl/alu_ctrl_unit_if.sv
// alu_ctrl_unit_if
// Groups the ID->EX handshake and result signals of the ALU control unit.
//   i_flush        : synchronous pipeline flush
//   i_valid/o_ready: request handshake (ALUOp/funct in)
//   i_ALUOp,i_func : operation class and funct field from the main decoder
//   o_valid/i_ready: result handshake (decoded control out)
//   o_ALU_control  : ALU control code
//   o_illegal      : unsupported ALUOp/funct
//   o_mc_start     : one-cycle start pulse to the mult/div unit
//   o_mc_op        : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   o_busy         : multi-cycle op in progress
// Modport slave is the control unit itself; master is the surrounding pipeline.
interface alu_ctrl_unit_if #(
  parameter int WIDTH_FUNC      = 6,
  parameter int WIDTH_ALU_OP    = 3,
  parameter int WIDTH_ALU_CNTRL = 4
) ();
  logic                       i_flush;
  logic                       i_valid;
  logic                       o_ready;
  logic [WIDTH_ALU_OP-1:0]    i_ALUOp;
  logic [WIDTH_FUNC-1:0]      i_func;
  logic                       o_valid;
  logic                       i_ready;
  logic [WIDTH_ALU_CNTRL-1:0] o_ALU_control;
  logic                       o_illegal;
  logic                       o_mc_start;
  logic [1:0]                 o_mc_op;
  logic                       o_busy;

  modport master (
    output i_flush, i_valid, i_ALUOp, i_func, i_ready,
    input  o_ready, o_valid, o_ALU_control, o_illegal, o_mc_start, o_mc_op, o_busy
  );

  modport slave (
    input  i_flush, i_valid, i_ALUOp, i_func, i_ready,
    output o_ready, o_valid, o_ALU_control, o_illegal, o_mc_start, o_mc_op, o_busy
  );
endinterface

// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit
// Registered ALU control decoder for the pipelined/multi-cycle MIPS datapath.
// Decodes ALUOp/funct into an ALU control code behind a one-entry valid/ready
// output register, and launches MULT/MULTU/DIV/DIVU on the mult/div unit,
// holding off new decodes for the op's busy period.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : alu_ctrl_unit_if.slave (handshake, decode inputs, results)
module alu_ctrl_unit #(
  parameter int WIDTH_FUNC      = 6,
  parameter int WIDTH_ALU_OP    = 3,
  parameter int WIDTH_ALU_CNTRL = 4,
  parameter int MULT_CYCLES     = 4,
  parameter int DIV_CYCLES      = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  alu_ctrl_unit_if.slave bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic       illegal;
    logic       mc;
    logic [3:0] ctl;
  } dec_t;

  // Pure decode of one request; illegal ops always yield control 0000.
  function automatic dec_t decode(input logic [WIDTH_ALU_OP-1:0] op,
                                  input logic [WIDTH_FUNC-1:0]   fn);
    dec_t d;
    d = '0;
    if ((op >> 3) != '0) begin
      d.illegal = 1'b1;
    end else begin
      case (op[2:0])
        3'b000: d.ctl = 4'b0010;
        3'b001: d.ctl = 4'b0110;
        3'b011: d.ctl = 4'b0000;
        3'b100: d.ctl = 4'b0001;
        3'b101: d.ctl = 4'b0111;
        3'b110: d.ctl = 4'b0011;
        3'b010: begin
          // funct bits above [5:0] must be zero for a legal R-type op
          if ((fn >> 6) != '0) begin
            d.illegal = 1'b1;
          end else begin
            case (fn[5:0])
              6'b100000, 6'b100001: d.ctl = 4'b0010;
              6'b100010, 6'b100011: d.ctl = 4'b0110;
              6'b100100:            d.ctl = 4'b0000;
              6'b100101:            d.ctl = 4'b0001;
              6'b100110:            d.ctl = 4'b0011;
              6'b100111:            d.ctl = 4'b1100;
              6'b101010:            d.ctl = 4'b0111;
              6'b000000:            d.ctl = 4'b1000;
              6'b000010:            d.ctl = 4'b1001;
              6'b000011:            d.ctl = 4'b1010;
              6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                d.mc  = 1'b1;
                d.ctl = 4'b1101;
              end
              default:              d.illegal = 1'b1;
            endcase
          end
        end
        default: d.illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [3:0]       ctl_q, ctl_d;
  logic             illegal_q, illegal_d;
  logic             mc_start_q, mc_start_d;
  logic [1:0]       mc_op_q, mc_op_d;
  logic             ready;
  logic             accept;
  dec_t             dec;

  // Ready never looks at i_valid so upstream may gate valid on ready.
  assign ready  = (state_q == IDLE) && !bus.i_flush && (!valid_q || bus.i_ready);
  assign accept = bus.i_valid && ready;

  always_comb begin
    dec        = decode(bus.i_ALUOp, bus.i_func);
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q && !bus.i_ready;
    ctl_d      = ctl_q;
    illegal_d  = illegal_q;
    mc_start_d = 1'b0;
    mc_op_d    = mc_op_q;

    if (bus.i_flush) begin
      valid_d   = 1'b0;
      state_d   = IDLE;
      cnt_d     = '0;
      illegal_d = 1'b0;
    end else begin
      if (state_q == BUSY) begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // Accept is only possible in IDLE, so it never collides with the countdown.
      if (accept) begin
        valid_d   = 1'b1;
        ctl_d     = dec.ctl;
        illegal_d = dec.illegal;
        mc_op_d   = dec.mc ? bus.i_func[1:0] : 2'b00;
        if (dec.mc) begin
          mc_start_d = 1'b1;
          state_d    = BUSY;
          cnt_d      = bus.i_func[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      ctl_q      <= 4'b0000;
      illegal_q  <= 1'b0;
      mc_start_q <= 1'b0;
      mc_op_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      ctl_q      <= ctl_d;
      illegal_q  <= illegal_d;
      mc_start_q <= mc_start_d;
      mc_op_q    <= mc_op_d;
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_valid       = valid_q;
  assign bus.o_ALU_control = WIDTH_ALU_CNTRL'(ctl_q);
  assign bus.o_illegal     = illegal_q;
  assign bus.o_mc_start    = mc_start_q;
  assign bus.o_mc_op       = mc_op_q;
  assign bus.o_busy        = (state_q == BUSY);

endmodule

// File: tb/tb_alu_ctrl_unit.sv
module tb_alu_ctrl_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_ctrl_unit_if #(.WIDTH_FUNC(6), .WIDTH_ALU_OP(3), .WIDTH_ALU_CNTRL(4)) bus ();

  alu_ctrl_unit #(
    .WIDTH_FUNC(6), .WIDTH_ALU_OP(3), .WIDTH_ALU_CNTRL(4),
    .MULT_CYCLES(4), .DIV_CYCLES(32)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch a multi-cycle op, then measure busy length, start-pulse count and
  // ready during busy; a plain add waits upstream and must enter right after.
  task automatic run_mc(input string tag, input logic [5:0] fn,
                        input int exp_n, input logic [1:0] exp_op);
    int b;
    int mcs;
    int rdy_seen;
    bus.i_valid = 1'b1;
    bus.i_ALUOp = 3'b010;
    bus.i_func  = fn;
    tick();
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
    chk({tag, "_ctl"}, 32'(bus.o_ALU_control), 32'hD);
    chk({tag, "_mc_op"}, 32'(bus.o_mc_op), 32'(exp_op));
    bus.i_ALUOp = 3'b000;
    bus.i_func  = 6'b000000;
    b = 0;
    mcs = 0;
    rdy_seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (!bus.o_busy) break;
      b++;
      if (bus.o_mc_start) mcs++;
      if (bus.o_ready) rdy_seen++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 32'(b), 32'(exp_n));
    chk({tag, "_start_pulses"}, 32'(mcs), 32'd1);
    chk({tag, "_ready_in_busy"}, 32'(rdy_seen), 32'd0);
    chk({tag, "_drained"}, 32'(bus.o_valid), 32'd0);
    chk({tag, "_ready_after"}, 32'(bus.o_ready), 32'd1);
    tick();
    chk({tag, "_next_valid"}, 32'(bus.o_valid), 32'd1);
    chk({tag, "_next_ctl"}, 32'(bus.o_ALU_control), 32'h2);
    chk({tag, "_next_mc_op"}, 32'(bus.o_mc_op), 32'd0);
    chk({tag, "_next_start"}, 32'(bus.o_mc_start), 32'd0);
    bus.i_valid = 1'b0;
    tick();
  endtask

  logic [2:0] s_op  [4];
  logic [3:0] s_exp [4];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n         = 1'b1;
    bus.i_flush   = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_ALUOp   = 3'b000;
    bus.i_func    = 6'b000000;
    bus.i_ready   = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_ctl", 32'(bus.o_ALU_control), 32'd0);
    chk("rst_illegal", 32'(bus.o_illegal), 32'd0);
    chk("rst_start", 32'(bus.o_mc_start), 32'd0);
    chk("rst_mc_op", 32'(bus.o_mc_op), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // NOR through R-type decode
    bus.i_valid = 1'b1;
    bus.i_ALUOp = 3'b010;
    bus.i_func  = 6'b100111;
    #1 chk("nor_ready", 32'(bus.o_ready), 32'd1);
    tick();
    bus.i_valid = 1'b0;
    chk("nor_valid", 32'(bus.o_valid), 32'd1);
    chk("nor_ctl", 32'(bus.o_ALU_control), 32'hC);
    chk("nor_illegal", 32'(bus.o_illegal), 32'd0);
    tick();
    chk("nor_valid_drop", 32'(bus.o_valid), 32'd0);

    // X on inputs while not valid must not leak
    bus.i_ALUOp = 'x;
    bus.i_func  = 'x;
    tick();
    tick();
    chk("x_valid", 32'(bus.o_valid), 32'd0);
    chk("x_ctl_held", 32'(bus.o_ALU_control), 32'hC);
    chk("x_illegal", 32'(bus.o_illegal), 32'd0);
    chk("x_busy", 32'(bus.o_busy), 32'd0);
    bus.i_func = 6'b000000;

    // Back-to-back stream
    s_op[0] = 3'b000; s_exp[0] = 4'b0010;
    s_op[1] = 3'b001; s_exp[1] = 4'b0110;
    s_op[2] = 3'b011; s_exp[2] = 4'b0000;
    s_op[3] = 3'b110; s_exp[3] = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      bus.i_valid = 1'b1;
      bus.i_ALUOp = s_op[i];
      #1 chk("stream_ready", 32'(bus.o_ready), 32'd1);
      tick();
      chk("stream_valid", 32'(bus.o_valid), 32'd1);
      chk("stream_ctl", 32'(bus.o_ALU_control), 32'(s_exp[i]));
    end
    bus.i_valid = 1'b0;
    tick();
    chk("stream_drain", 32'(bus.o_valid), 32'd0);

    // Backpressure
    bus.i_valid = 1'b1;
    bus.i_ALUOp = 3'b000;
    tick();
    bus.i_ready = 1'b0;
    bus.i_ALUOp = 3'b001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(bus.o_ready), 32'd0);
      chk("bp_valid", 32'(bus.o_valid), 32'd1);
      chk("bp_ctl", 32'(bus.o_ALU_control), 32'h2);
      tick();
    end
    bus.i_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(bus.o_ready), 32'd1);
    tick();
    chk("bp_new_valid", 32'(bus.o_valid), 32'd1);
    chk("bp_new_ctl", 32'(bus.o_ALU_control), 32'h6);
    bus.i_valid = 1'b0;
    tick();
    chk("bp_drain", 32'(bus.o_valid), 32'd0);

    // Multi-cycle ops
    run_mc("div", 6'b011010, 32, 2'b10);
    run_mc("mult", 6'b011000, 4, 2'b00);
    run_mc("divu", 6'b011011, 32, 2'b11);

    // Illegal ops
    bus.i_valid = 1'b1;
    bus.i_ALUOp = 3'b111;
    tick();
    chk("ill_op_valid", 32'(bus.o_valid), 32'd1);
    chk("ill_op_flag", 32'(bus.o_illegal), 32'd1);
    chk("ill_op_ctl", 32'(bus.o_ALU_control), 32'd0);
    chk("ill_op_start", 32'(bus.o_mc_start), 32'd0);
    bus.i_ALUOp = 3'b010;
    bus.i_func  = 6'b001111;
    tick();
    chk("ill_fn_flag", 32'(bus.o_illegal), 32'd1);
    chk("ill_fn_ctl", 32'(bus.o_ALU_control), 32'd0);
    chk("ill_fn_start", 32'(bus.o_mc_start), 32'd0);
    chk("ill_fn_busy", 32'(bus.o_busy), 32'd0);
    bus.i_ALUOp = 3'b100;
    tick();
    chk("legal_after_ill", 32'(bus.o_illegal), 32'd0);
    chk("legal_after_ill_ctl", 32'(bus.o_ALU_control), 32'h1);
    bus.i_valid = 1'b0;
    tick();

    // Flush at busy cycle 5 of a DIV
    bus.i_valid = 1'b1;
    bus.i_ALUOp = 3'b010;
    bus.i_func  = 6'b011010;
    tick();
    bus.i_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("fl_busy_before", 32'(bus.o_busy), 32'd1);
    bus.i_flush = 1'b1;
    #1 chk("fl_ready_in_flush", 32'(bus.o_ready), 32'd0);
    tick();
    bus.i_flush = 1'b0;
    #1;
    chk("fl_busy", 32'(bus.o_busy), 32'd0);
    chk("fl_valid", 32'(bus.o_valid), 32'd0);
    chk("fl_ready", 32'(bus.o_ready), 32'd1);
    chk("fl_illegal", 32'(bus.o_illegal), 32'd0);
    bus.i_valid = 1'b1;
    bus.i_ALUOp = 3'b100;
    tick();
    chk("fl_accept_ctl", 32'(bus.o_ALU_control), 32'h1);
    chk("fl_accept_valid", 32'(bus.o_valid), 32'd1);
    bus.i_valid = 1'b0;
    tick();

    // Async reset mid-busy
    bus.i_valid = 1'b1;
    bus.i_ALUOp = 3'b010;
    bus.i_func  = 6'b011010;
    tick();
    bus.i_valid = 1'b0;
    tick();
    tick();
    chk("ar_busy_before", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(bus.o_busy), 32'd0);
    chk("ar_valid", 32'(bus.o_valid), 32'd0);
    chk("ar_ctl", 32'(bus.o_ALU_control), 32'd0);
    chk("ar_mc_op", 32'(bus.o_mc_op), 32'd0);
    chk("ar_illegal", 32'(bus.o_illegal), 32'd0);
    chk("ar_start", 32'(bus.o_mc_start), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_busy_after", 32'(bus.o_busy), 32'd0);
    chk("ar_ready_after", 32'(bus.o_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_unit.md
Name: alu_ctrl_unit

Overview:
Parametrised, registered successor to the single-cycle ALU control decoder, built for the pipelined/multi-cycle MIPS datapath. It decodes ALUOp and funct into an ALU control code through a one-entry valid/ready output register. It also recognises MIPS multi-cycle ops (MULT/MULTU/DIV/DIVU), issues a start pulse for them, and holds off new decodes with a busy counter. Sits between the main control decoder (ID stage) and the ALU/mult-div unit (EX stage).

Parameters:
WIDTH_FUNC, 6, funct field width; bits above [5:0] must be zero, otherwise the op is illegal
WIDTH_ALU_OP, 3, ALUOp width; minimum 3
WIDTH_ALU_CNTRL, 4, ALU control width; minimum 4, upper bits driven 0
MULT_CYCLES, 4, busy cycles for MULT/MULTU; minimum 1
DIV_CYCLES, 32, busy cycles for DIV/DIVU; minimum 1

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  synchronous pipeline flush
i_valid  in  1  ALUOp/funct valid
o_ready  out  1  block can accept this cycle
i_ALUOp  in  WIDTH_ALU_OP  ALU operation class from main decoder
i_func  in  WIDTH_FUNC  instruction funct field
o_valid  out  1  decoded result valid
i_ready  in  1  consumer accepts result
o_ALU_control  out  WIDTH_ALU_CNTRL  ALU control code
o_illegal  out  1  unsupported ALUOp/funct
o_mc_start  out  1  one-cycle start pulse to mult/div unit
o_mc_op  out  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
o_busy  out  1  multi-cycle op in progress

Behaviour:
- Reset (i_rst_n=0, async): o_valid, o_ALU_control, o_illegal, o_mc_start, o_mc_op, o_busy all 0; FSM in IDLE; counter 0.
- FSM states: IDLE and BUSY. o_busy = (state==BUSY).
- o_ready = !o_busy && !i_flush && (!o_valid || i_ready). Purely combinational; never depends on i_valid.
- Accept when i_valid && o_ready. Latency is 1 cycle: the decoded result is registered and o_valid=1 the next cycle.
- Hold: while o_valid && !i_ready, all outputs except o_mc_start stay stable. o_valid drops after a transfer if nothing new was accepted in the same cycle. Back-to-back throughput is 1 per cycle.
- ALUOp decode:
  - 000 add 0010 (lw/sw/addi)
  - 001 sub 0110 (beq/bne)
  - 010 R-type via funct
  - 011 and 0000
  - 100 or 0001
  - 101 slt 0111
  - 110 xor 0011
  - 111 illegal
- funct decode (ALUOp=010):
  - 100000/100001 add 0010
  - 100010/100011 sub 0110
  - 100100 and 0000
  - 100101 or 0001
  - 100110 xor 0011
  - 100111 nor 1100
  - 101010 slt 0111
  - 000000 sll 1000
  - 000010 srl 1001
  - 000011 sra 1010
  - 011000..011011 multi-cycle, o_mc_op = funct[1:0], control 1101
- Illegal op: o_illegal=1, o_ALU_control=0, no multi-cycle action. It is still delivered as a normal valid result.
- Multi-cycle op accepted:
  - next cycle: o_valid=1, o_mc_start=1 for exactly that one cycle, independent of i_ready.
  - state goes to BUSY; counter loads N (MULT_CYCLES for 0110 00/01, DIV_CYCLES for 0110 10/11).
  - counter decrements each BUSY cycle; at counter==1 the FSM returns to IDLE.
  - result: o_busy high for exactly N cycles. The earliest next accept is N+1 cycles after the multi-cycle accept, provided the output has drained.
- Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- i_flush (synchronous; priority below reset, above everything else):
  - next state: o_valid=0, o_mc_start=0, o_busy=0, state IDLE, counter 0, o_illegal=0.
  - no accept occurs in the flush cycle.
  - an in-progress busy period is aborted.
- Reset asserted mid-BUSY: immediate return to the reset values.
- X on i_func/i_ALUOp while i_valid=0 must not propagate to outputs. Outputs are never X after reset.

Test Plan:
- Reset then ALUOp=010, funct=100111, i_ready=1 -> one cycle later o_valid=1, o_ALU_control=1100, o_illegal=0; o_valid=0 the cycle after.
- Stream ALUOp 000, 001, 011, 110 on consecutive cycles with i_ready=1 -> outputs 0010, 0110, 0000, 0011 on consecutive cycles; o_ready stays 1 throughout.
- Backpressure: accept add, hold i_ready=0 for 3 cycles -> o_ready=0 and outputs stable at 0010; on i_ready=1 a new op is accepted in the same cycle.
- ALUOp=010, funct=011010 (DIV), DIV_CYCLES=32:
  - o_mc_start=1 for one cycle, o_mc_op=10.
  - o_busy=1 for exactly 32 cycles; o_ready=0 throughout.
  - next accept in cycle 33. Repeat with MULT: busy for 4 cycles.
- ALUOp=111, then ALUOp=010 with funct=001111 -> o_illegal=1, o_ALU_control=0000, o_mc_start=0.
- Start DIV, assert i_flush at busy cycle 5 -> next cycle o_busy=0, o_valid=0, o_ready=1. Separately, assert i_rst_n=0 mid-busy -> all outputs 0 immediately.
